// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that sits directly upstream of ctrl_unit and owns
//   the program counter. On a microcode fetch command it reads one 16-bit
//   instruction word from instruction memory over a req/ack handshake, latches
//   it into the instruction register and presents ir[15:11] as the opcode.
//   Microcode jumps reload the PC. A jump that arrives while a fetch is in
//   flight is held pending and applied when that fetch completes or aborts.
//   A fetch that waits TIMEOUT cycles without an ack is aborted, and
//   fetch_err pulses for one cycle.
//
// Ports
//   clk         in   1       clock, all state updates on posedge
//   rst         in   1       asynchronous, active-high reset
//   fetch_en    in   1       microcode: start a fetch at current PC
//   jmp_en      in   1       microcode: load PC from jmp_addr
//   jmp_addr    in   ADDR_W  jump target
//   imem_req    out  1       read request to instruction memory
//   imem_addr   out  ADDR_W  read address, stable while imem_req=1
//   imem_ack    in   1       memory: imem_rdata valid this cycle
//   imem_rdata  in   16      instruction word from memory
//   ir          out  16      instruction register
//   opcode      out  5       ir[15:11], combinational, to ctrl_unit
//   ir_valid    out  1       ir holds a completed fetch
//   busy        out  1       fetch in progress (state REQ)
//   fetch_err   out  1       one-cycle pulse on timeout abort
//   pc          out  ADDR_W  current program counter
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       ir,
  output logic [4:0]        opcode,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] pc
);

  // Wide enough to hold TIMEOUT-1; TIMEOUT >= 1 keeps this at least 1 bit.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              jmp_pend_r;
  logic [ADDR_W-1:0] jmp_target_r;

  // Sequential address after the one just fetched; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] addr);
    pc_inc = addr + ADDR_W'(1);
  endfunction

  // Opcode is a plain tap of the instruction register for ctrl_unit's decode.
  assign opcode = ir[15:11];

  // busy mirrors the REQ state, which is itself a register.
  assign busy = (state_r == ST_REQ);

  // Fetch FSM: owns pc, ir, handshake outputs, the timeout counter and the
  // pending-jump slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pc           <= ADDR_W'(RESET_PC);
      ir           <= 16'h0000;
      ir_valid     <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= {ADDR_W{1'b0}};
      fetch_err    <= 1'b0;
      wait_cnt_r   <= {CNT_W{1'b0}};
      jmp_pend_r   <= 1'b0;
      jmp_target_r <= {ADDR_W{1'b0}};
    end else begin
      // fetch_err is a single-cycle pulse unless re-raised below.
      fetch_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fetch_en) begin
            // A simultaneous jump supplies the fetch address as well as the PC.
            state_r    <= ST_REQ;
            imem_req   <= 1'b1;
            ir_valid   <= 1'b0;
            wait_cnt_r <= {CNT_W{1'b0}};
            jmp_pend_r <= 1'b0;
            if (jmp_en) begin
              pc        <= jmp_addr;
              imem_addr <= jmp_addr;
            end else begin
              imem_addr <= pc;
            end
          end else if (jmp_en) begin
            pc <= jmp_addr;
          end else begin
            pc <= pc;
          end
        end

        ST_REQ: begin
          if (imem_ack) begin
            ir         <= imem_rdata;
            ir_valid   <= 1'b1;
            state_r    <= ST_IDLE;
            imem_req   <= 1'b0;
            jmp_pend_r <= 1'b0;
            // Newest jump wins, then a pending one, else fall through.
            if (jmp_en) begin
              pc <= jmp_addr;
            end else if (jmp_pend_r) begin
              pc <= jmp_target_r;
            end else begin
              pc <= pc_inc(imem_addr);
            end
          end else if (wait_cnt_r == CNT_LAST) begin
            // Abort: ir and ir_valid untouched, PC only moves for a jump.
            fetch_err  <= 1'b1;
            state_r    <= ST_IDLE;
            imem_req   <= 1'b0;
            jmp_pend_r <= 1'b0;
            if (jmp_en) begin
              pc <= jmp_addr;
            end else if (jmp_pend_r) begin
              pc <= jmp_target_r;
            end else begin
              pc <= pc;
            end
          end else begin
            // Still waiting; a jump here does not cancel the in-flight fetch.
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            if (jmp_en) begin
              jmp_pend_r   <= 1'b1;
              jmp_target_r <= jmp_addr;
            end else begin
              jmp_pend_r <= jmp_pend_r;
            end
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Each task drives one scenario and compares
//   outputs against hand-computed values; inputs change and outputs are
//   sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        jmp_en = 1'b0;
  logic [7:0]  jmp_addr = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;
  logic [7:0]  pc;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.ADDR_W(8), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .ir_valid   (ir_valid),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if ({pc, ir, ir_valid, imem_req, imem_addr, fetch_err, busy} !== {8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got pc=%h ir=%h v=%b req=%b addr=%h err=%b busy=%b want all zero",
               pc, ir, ir_valid, imem_req, imem_addr, fetch_err, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({pc, busy} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_idle got pc=%h busy=%b want 00 0", pc, busy);
    end
  endtask

  task automatic test_basic_fetch();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    checks++;
    if ({imem_req, busy, imem_addr} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL basic_req got req=%b busy=%b addr=%h want 1 1 00", imem_req, busy, imem_addr);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h3A05;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({ir, opcode, ir_valid, pc, imem_req} !== {16'h3A05, 5'b00111, 1'b1, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL basic_done got ir=%h op=%b v=%b pc=%h req=%b want 3a05 00111 1 01 0",
               ir, opcode, ir_valid, pc, imem_req);
    end
    // Ack while idle must be ignored.
    imem_ack = 1'b1;
    imem_rdata = 16'hFFFF;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, pc, imem_req} !== {16'h3A05, 1'b1, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL idle_ack got ir=%h v=%b pc=%h req=%b want 3a05 1 01 0", ir, ir_valid, pc, imem_req);
    end
  endtask

  task automatic test_delayed_ack();
    int bad;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if ({imem_req, busy, imem_addr, ir_valid} !== {1'b1, 1'b1, 8'h00, 1'b0}) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL delay_hold got %0d bad cycles want 0", bad);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h1111;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({pc, ir, ir_valid, busy} !== {8'h01, 16'h1111, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL delay_done got pc=%h ir=%h v=%b busy=%b want 01 1111 1 0", pc, ir, ir_valid, busy);
    end
  endtask

  task automatic test_wrap();
    jmp_en = 1'b1;
    jmp_addr = 8'hFF;
    step();
    jmp_en = 1'b0;
    checks++;
    if ({pc, busy} !== {8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL idle_jump got pc=%h busy=%b want ff 0", pc, busy);
    end
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    checks++;
    if ({imem_addr, ir_valid} !== {8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL wrap_addr got addr=%h v=%b want ff 0", imem_addr, ir_valid);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h2222;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({pc, ir} !== {8'h00, 16'h2222}) begin
      failures++;
      $display("FAIL wrap_pc got pc=%h ir=%h want 00 2222", pc, ir);
    end
  endtask

  task automatic test_pending_jump();
    jmp_en = 1'b1;
    jmp_addr = 8'h05;
    step();
    jmp_en = 1'b0;
    fetch_en = 1'b1;
    step();
    // First jump in REQ, then a later one overwrites it; fetch_en is ignored.
    jmp_en = 1'b1;
    jmp_addr = 8'h30;
    step();
    jmp_addr = 8'h40;
    step();
    jmp_en = 1'b0;
    fetch_en = 1'b0;
    checks++;
    if ({busy, imem_addr, pc} !== {1'b1, 8'h05, 8'h05}) begin
      failures++;
      $display("FAIL pend_hold got busy=%b addr=%h pc=%h want 1 05 05", busy, imem_addr, pc);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h3333;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({pc, ir, ir_valid} !== {8'h40, 16'h3333, 1'b1}) begin
      failures++;
      $display("FAIL pend_apply got pc=%h ir=%h v=%b want 40 3333 1", pc, ir, ir_valid);
    end
  endtask

  task automatic test_fetch_and_jump();
    fetch_en = 1'b1;
    jmp_en = 1'b1;
    jmp_addr = 8'h20;
    step();
    fetch_en = 1'b0;
    jmp_en = 1'b0;
    checks++;
    if ({imem_addr, pc, busy} !== {8'h20, 8'h20, 1'b1}) begin
      failures++;
      $display("FAIL fj_addr got addr=%h pc=%h busy=%b want 20 20 1", imem_addr, pc, busy);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h4444;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({pc, ir} !== {8'h21, 16'h4444}) begin
      failures++;
      $display("FAIL fj_done got pc=%h ir=%h want 21 4444", pc, ir);
    end
  endtask

  task automatic test_jump_with_ack();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    jmp_en = 1'b1;
    jmp_addr = 8'h50;
    step();
    jmp_addr = 8'h77;
    imem_ack = 1'b1;
    imem_rdata = 16'h1234;
    step();
    jmp_en = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if ({pc, ir, busy} !== {8'h77, 16'h1234, 1'b0}) begin
      failures++;
      $display("FAIL jmp_ack got pc=%h ir=%h busy=%b want 77 1234 0", pc, ir, busy);
    end
  endtask

  task automatic test_back_to_back();
    jmp_en = 1'b1;
    jmp_addr = 8'h60;
    step();
    jmp_en = 1'b0;
    fetch_en = 1'b1;
    step();
    imem_ack = 1'b1;
    imem_rdata = 16'hA001;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({ir, pc, busy} !== {16'hA001, 8'h61, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first got ir=%h pc=%h busy=%b want a001 61 0", ir, pc, busy);
    end
    step();
    checks++;
    if ({busy, imem_addr, ir_valid} !== {1'b1, 8'h61, 1'b0}) begin
      failures++;
      $display("FAIL b2b_req2 got busy=%b addr=%h v=%b want 1 61 0", busy, imem_addr, ir_valid);
    end
    fetch_en = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'hB002;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({ir, pc, ir_valid} !== {16'hB002, 8'h62, 1'b1}) begin
      failures++;
      $display("FAIL b2b_second got ir=%h pc=%h v=%b want b002 62 1", ir, pc, ir_valid);
    end
    // Restore pc=77 for the timeout scenario.
    jmp_en = 1'b1;
    jmp_addr = 8'h77;
    step();
    jmp_en = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    bad = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if ({busy, imem_req, fetch_err} !== {1'b1, 1'b1, 1'b0}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL to_wait got %0d bad cycles want 0", bad);
    end
    step();
    checks++;
    if ({fetch_err, busy, imem_req, ir_valid, pc, ir} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 16'hB002}) begin
      failures++;
      $display("FAIL to_abort got err=%b busy=%b req=%b v=%b pc=%h ir=%h want 1 0 0 0 77 b002",
               fetch_err, busy, imem_req, ir_valid, pc, ir);
    end
    step();
    checks++;
    if (fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse got err=%b want 0", fetch_err);
    end
    // Timeout with a pending jump lands on the jump target.
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    jmp_en = 1'b1;
    jmp_addr = 8'h10;
    for (int i = 1; i <= 15; i++) begin
      step();
      jmp_en = 1'b0;
    end
    checks++;
    if ({fetch_err, pc, busy} !== {1'b1, 8'h10, 1'b0}) begin
      failures++;
      $display("FAIL to_pend got err=%b pc=%h busy=%b want 1 10 0", fetch_err, pc, busy);
    end
  endtask

  task automatic test_reset_in_req();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    jmp_en = 1'b1;
    jmp_addr = 8'h99;
    step();
    jmp_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, busy, pc, ir_valid} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL rst_async got req=%b busy=%b pc=%h v=%b want 0 0 00 0", imem_req, busy, pc, ir_valid);
    end
    #2;
    rst = 1'b0;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({pc, ir} !== {8'h01, 16'hBEEF}) begin
      failures++;
      $display("FAIL rst_pend_drop got pc=%h ir=%h want 01 beef", pc, ir);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_wrap();
    test_pending_jump();
    test_fetch_and_jump();
    test_jump_with_ack();
    test_back_to_back();
    test_timeout();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
